// File: rtl/nes_pad_target.sv
// nes_pad_target: I2C target emulating a NES pad with an 8-byte register window.
// Define NES_TARGET_GLITCH_FILTER_EN to add a 3-sample stability filter on scl/sda.
module nes_pad_target #(
  parameter logic [6:0] ADDR = 7'h52,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out,
  input  logic [15:0] buttons,
  output logic        busy,
  output logic        read_done
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop;
  logic [3:0] cnt;
  logic [7:0] sr, tx, rd_byte;
  logic [2:0] ptr;
  logic [15:0] snap, src;
  logic first;
  always_ff @(posedge clk)
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
`ifdef NES_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic scl_q, sda_q, scl_raw, sda_raw;
  assign scl_raw = scl_sync[SYNC_STAGES-1];
  assign sda_raw = sda_sync[SYNC_STAGES-1];
  // A new level is accepted only once it has been seen on three consecutive samples
  assign scl_s = (scl_h == {2{scl_raw}}) ? scl_raw : scl_q;
  assign sda_s = (sda_h == {2{sda_raw}}) ? sda_raw : sda_q;
  always_ff @(posedge clk)
    if (rst) begin
      scl_h <= '1;
      sda_h <= '1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_raw};
      sda_h <= {sda_h[0], sda_raw};
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
`else
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
`endif
  always_ff @(posedge clk)
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  always_comb begin
    scl_rise = scl_s & ~scl_d;
    scl_fall = ~scl_s & scl_d;
    start = scl_s & scl_d & sda_d & ~sda_s;
    stop = scl_s & scl_d & ~sda_d & sda_s;
    src = (state == S_ADDR_ACK) ? buttons : snap;
    rd_byte = !ptr[2] ? 8'h00 : ptr[1] ? 8'hFF : ptr[0] ? ~src[7:0] : ~src[15:8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sda_out <= 1'b1;
      busy <= 1'b0;
      read_done <= 1'b0;
      ptr <= '0;
      snap <= '0;
      cnt <= '0;
      sr <= '0;
      tx <= '0;
      first <= 1'b0;
    end else begin
      read_done <= 1'b0;
      if (start) begin
        state <= S_ADDR;
        cnt <= '0;
        sda_out <= 1'b1;
      end else if (stop) begin
        state <= S_IDLE;
        sda_out <= 1'b1;
        busy <= 1'b0;
      end else if (scl_rise) begin
        // cnt parks at 8 through ACK slots so the ACK bit never disturbs sr
        if (cnt != 4'd8) begin
          cnt <= cnt + 4'd1;
          sr <= {sr[6:0], sda_s};
        end
        if (state == S_RD_ACK && sda_s) begin
          read_done <= 1'b1;
          state <= S_IGNORE;
        end
      end else if (scl_fall) begin
        case (state)
          S_ADDR: if (cnt == 4'd8) begin
            state <= (sr[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
            sda_out <= sr[7:1] != ADDR;
            busy <= sr[7:1] == ADDR;
          end
          S_ADDR_ACK: begin
            cnt <= '0;
            if (sr[0]) begin
              snap <= buttons;
              tx <= rd_byte;
              sda_out <= rd_byte[7];
              state <= S_RD_BYTE;
            end else begin
              sda_out <= 1'b1;
              first <= 1'b1;
              state <= S_WR_BYTE;
            end
          end
          S_WR_BYTE: if (cnt == 4'd8) begin
            state <= S_WR_ACK;
            sda_out <= 1'b0;
            ptr <= first ? sr[2:0] : ptr + 3'd1;
            first <= 1'b0;
          end
          S_WR_ACK: begin
            sda_out <= 1'b1;
            cnt <= '0;
            state <= S_WR_BYTE;
          end
          S_RD_BYTE: if (cnt == 4'd8) begin
            state <= S_RD_ACK;
            sda_out <= 1'b1;
            ptr <= ptr + 3'd1;
          end else begin
            sda_out <= tx[6];
            tx <= {tx[6:0], 1'b0};
          end
          S_RD_ACK: begin
            tx <= rd_byte;
            sda_out <= rd_byte[7];
            cnt <= '0;
            state <= S_RD_BYTE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
